// File: rtl/fadd_accum_ctrl.sv
// fadd_accum_ctrl: sequential float32 reduction controller in front of a
// combinational fadd block; sums a job's operand stream in stream order.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_len      job start pulse and operand count (sampled in IDLE)
//   o_busy              controller not idle
//   i_in_valid/o_in_ready, i_in_data   operand stream handshake
//   o_add_a, o_add_b    registered operands to fadd (acc, opnd)
//   i_add_res, i_add_ovf  fadd result/overflow, captured only in ADD
//   o_out_valid/i_out_ready, o_out_data, o_out_ovf  result handshake
module fadd_accum_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy,
  input  logic             i_in_valid,
  input  logic [31:0]      i_in_data,
  output logic             o_in_ready,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  input  logic [31:0]      i_add_res,
  input  logic             i_add_ovf,
  output logic             o_out_valid,
  output logic [31:0]      o_out_data,
  output logic             o_out_ovf,
  input  logic             i_out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_acc;
  logic [31:0]      r_opnd;
  logic [CNT_W-1:0] r_rem;
  logic             r_first;
  logic             r_ovf;

  logic w_take;
  logic w_last;

  // Operand accepted this cycle (only possible while loading).
  assign w_take = (r_state == S_LOAD) && i_in_valid;
  // Last operand of the job is being accepted.
  assign w_last = (r_rem == CNT_W'(1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            w_next = S_DONE;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (i_in_valid) begin
          if (!r_first) begin
            w_next = S_ADD;
          end else if (w_last) begin
            w_next = S_DONE;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      S_ADD: begin
        if (r_rem == '0) begin
          w_next = S_DONE;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy      = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
      end
      S_LOAD: begin
        o_busy     = 1'b1;
        o_in_ready = 1'b1;
      end
      S_ADD: begin
        o_busy = 1'b1;
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  // fadd sees only registered values, so its full path gets a whole cycle.
  assign o_add_a    = r_acc;
  assign o_add_b    = r_opnd;
  assign o_out_data = r_acc;
  assign o_out_ovf  = r_ovf;

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= 32'h0;
      r_opnd  <= 32'h0;
      r_rem   <= '0;
      r_first <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rem   <= i_len;
            r_first <= 1'b1;
            r_ovf   <= 1'b0;
            r_acc   <= 32'h0;
          end
        end
        S_LOAD: begin
          if (w_take) begin
            r_rem <= r_rem - CNT_W'(1);
            // First operand is loaded directly so -0, NaN payloads and
            // exact bit patterns survive a single-element job.
            if (r_first) begin
              r_acc   <= i_in_data;
              r_first <= 1'b0;
            end else begin
              r_opnd <= i_in_data;
            end
          end
        end
        S_ADD: begin
          r_acc <= i_add_res;
          r_ovf <= r_ovf | i_add_ovf;
        end
        S_DONE: begin
          r_first <= r_first;
        end
        default: begin
          r_first <= r_first;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_accum_ctrl.sv
// tb_fadd_accum_ctrl: table vectors, directed corner sequences and random
// jobs checked against an integer-sum reference, with a float adder model.
module tb_fadd_accum_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len_i;
  logic             busy;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_res;
  logic             add_ovf;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ovf;
  logic             out_ready;
  logic             force_ovf;

  always #5 clk = ~clk;

  fadd_accum_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_len      (len_i),
    .o_busy     (busy),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .i_add_res  (add_res),
    .i_add_ovf  (add_ovf),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .o_out_ovf  (out_ovf),
    .i_out_ready(out_ready)
  );

  // float32 <-> real helpers (denormals flushed to zero)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) d = {f[31], 63'b0};
    else if (f[30:23] == 8'hff) d = {f[31], 11'h7ff, f[22:0], 29'b0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Behavioural fadd: {ovf, res}
  function automatic logic [32:0] fadd_m(input logic [31:0] a,
                                         input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          e;
    r = f2r(a) + f2r(b);
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0) return {1'b0, d[63], 31'b0};
    if (e == 2047) return {1'b0, d[63], 8'hff, d[51:29]};
    e = e - 896;
    if (e >= 255) return {1'b1, d[63], 8'hff, 23'b0};
    if (e <= 0) return {1'b0, d[63], 31'b0};
    return {1'b0, d[63], e[7:0], d[51:29]};
  endfunction

  // Exact float32 encoding of a small integer
  function automatic logic [31:0] i2f(input int v);
    logic [31:0] a;
    logic [31:0] m;
    int          p;
    if (v == 0) return 32'h0;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (a[i]) p = i;
    m = a << (23 - p);
    return {(v < 0), 8'(127 + p), m[22:0]};
  endfunction

  logic [32:0] w_fadd;
  always_comb begin
    w_fadd  = fadd_m(add_a, add_b);
    add_res = w_fadd[31:0];
    add_ovf = w_fadd[32] | force_ovf;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, got, exp);
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", nm, got, exp);
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  bit ir_hist [0:63];

  // Runs one job; cycle 1 is the first cycle after the edge sampling start.
  task automatic run_job(input int len, input logic [31:0] ops[$],
                         input int gap, input bit rnd_gap,
                         input int rdy_dly, input bit junk_start,
                         input bit ovf_in_add,
                         output logic [31:0] d, output logic ov,
                         output int lat, output int vcyc,
                         output bit stable, output bit any_ir);
    int idx;
    int wait_n;
    bit acc;
    bit dn;
    bit to;
    idx = 0; d = '0; ov = 1'b0; lat = -1; vcyc = 0;
    stable = 1'b1; any_ir = 1'b0; to = 1'b1;
    for (int k = 0; k < 64; k++) ir_hist[k] = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; len_i = CNT_W'(len);
    @(posedge clk); #1;
    start = junk_start;
    wait_n = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
    for (int c = 1; c <= 400; c++) begin
      in_valid  = (idx < len) && (wait_n == 0);
      in_data   = in_valid ? ops[idx] : $urandom;
      force_ovf = ovf_in_add && busy && !in_ready && !out_valid;
      out_ready = 1'b0;
      if (out_valid) begin
        if (vcyc == 0) begin
          lat = c; d = out_data; ov = out_ovf;
        end else if (out_data !== d || out_ovf !== ov) begin
          stable = 1'b0;
        end
        out_ready = (vcyc >= rdy_dly);
        vcyc++;
      end
      @(negedge clk);
      if (c < 64) ir_hist[c] = in_ready;
      if (in_ready) any_ir = 1'b1;
      acc = in_valid && in_ready;
      dn  = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) wait_n = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
      else if (wait_n > 0) wait_n--;
      if (acc) idx++;
      if (dn) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; force_ovf = 1'b0;
    if (to) begin
      n_chk++;
      $display("FAIL job_timeout: got no result expected result len=%0d", len);
    end
  endtask

  typedef struct {
    int          len;
    logic [31:0] op [4];
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tv [6];

  initial begin
    logic [31:0] q[$];
    logic [31:0] d;
    logic        ov;
    int          lat, vcyc, sum, ln, gp;
    bit          stable, any_ir;

    tv[0] = '{3, '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h0},
              32'h40C00000, 6};
    tv[1] = '{0, '{32'h0, 32'h0, 32'h0, 32'h0}, 32'h00000000, 1};
    tv[2] = '{1, '{32'hBF800000, 32'h0, 32'h0, 32'h0}, 32'hBF800000, 2};
    tv[3] = '{1, '{32'h80000000, 32'h0, 32'h0, 32'h0}, 32'h80000000, 2};
    tv[4] = '{2, '{32'h3F800000, 32'h3F800000, 32'h0, 32'h0},
              32'h40000000, 4};
    tv[5] = '{4, '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0400000},
              32'hBF800000, 8};

    rst = 1'b1; start = 1'b0; len_i = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0; force_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk1("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);

    for (int t = 0; t < 6; t++) begin
      q.delete();
      for (int k = 0; k < tv[t].len; k++) q.push_back(tv[t].op[k]);
      run_job(tv[t].len, q, 0, 1'b0, 0, 1'b0, 1'b0,
              d, ov, lat, vcyc, stable, any_ir);
      chk($sformatf("vec%0d_data", t), d, tv[t].exp);
      chk1($sformatf("vec%0d_ovf", t), ov, 1'b0);
      chki($sformatf("vec%0d_lat", t), lat, tv[t].lat);
      if (t == 0) begin
        chk1("vec0_ir_c3", ir_hist[3], 1'b0);
        chk1("vec0_ir_c5", ir_hist[5], 1'b0);
        chk1("vec0_ir_c4", ir_hist[4], 1'b1);
      end
      if (t == 1) chk1("vec1_no_in_ready", any_ir, 1'b0);
    end

    // Input gaps and a stalled sink: result must be held until accepted.
    q.delete();
    q.push_back(32'h3F800000); q.push_back(32'h3F800000);
    run_job(2, q, 3, 1'b0, 5, 1'b0, 1'b0, d, ov, lat, vcyc, stable, any_ir);
    chk("gap_data", d, 32'h40000000);
    chk1("gap_stable", stable, 1'b1);
    chki("gap_valid_cycles", vcyc, 6);

    // start held high while busy and during acceptance: no second job.
    q.delete();
    q.push_back(32'h40000000); q.push_back(32'h40400000);
    run_job(2, q, 0, 1'b0, 2, 1'b1, 1'b0, d, ov, lat, vcyc, stable, any_ir);
    chk("junk_data", d, 32'h40A00000);
    repeat (3) @(negedge clk);
    chk1("junk_idle_busy", busy, 1'b0);
    chk1("junk_idle_valid", out_valid, 1'b0);

    // Reset in the ADD cycle of a len=4 job.
    @(posedge clk); #1;
    start = 1'b1; len_i = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 32'h3F800000;
    @(posedge clk); #1;
    in_data = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("mid_in_add_ready", in_ready, 1'b0);
    chk1("mid_in_add_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_add_a", add_a, 32'h0);
    chk("mid_rst_add_b", add_b, 32'h0);
    q.delete();
    q.push_back(32'h3F800000); q.push_back(32'h40000000);
    run_job(2, q, 0, 1'b0, 0, 1'b0, 1'b0, d, ov, lat, vcyc, stable, any_ir);
    chk("post_rst_data", d, 32'h40400000);
    chk1("post_rst_ovf", ov, 1'b0);
    run_job(2, q, 0, 1'b0, 0, 1'b0, 1'b1, d, ov, lat, vcyc, stable, any_ir);
    chk("force_ovf_data", d, 32'h40400000);
    chk1("force_ovf_flag", ov, 1'b1);

    // Random jobs against an integer-sum reference.
    for (int j = 0; j < 25; j++) begin
      int v;
      ln  = $urandom_range(8, 0);
      gp  = (j % 2 == 0) ? 0 : int'($urandom_range(2, 1));
      sum = 0;
      q.delete();
      for (int k = 0; k < ln; k++) begin
        v = int'($urandom_range(2000, 0)) - 1000;
        sum += v;
        q.push_back(i2f(v));
      end
      run_job(ln, q, gp, 1'b1, int'($urandom_range(3, 0)), 1'b0, 1'b0,
              d, ov, lat, vcyc, stable, any_ir);
      chk($sformatf("rnd%0d_data", j), d, (ln == 0) ? 32'h0 : i2f(sum));
      chk1($sformatf("rnd%0d_ovf", j), ov, 1'b0);
      chk1($sformatf("rnd%0d_stable", j), stable, 1'b1);
      if (gp == 0)
        chki($sformatf("rnd%0d_lat", j), lat,
             (ln == 0) ? 1 : (ln == 1) ? 2 : 2 * ln);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
